// File: rtl/iob_unpack_pkg.sv
// rtl/iob_unpack_pkg.sv - shared types for the stream unpacker
// Contents: unpack_state_t, the four-step loop counter encoding.
package iob_unpack_pkg;

    typedef enum logic [1:0] {
        CALC_PUSH_WIDTH = 2'd0,
        WAIT_DATA       = 2'd1,
        PUSH_DATA       = 2'd2,
        WAIT_POP        = 2'd3
    } unpack_state_t;

endpackage

// File: rtl/iob_bfifo.sv
// rtl/iob_bfifo.sv - variable-width bit FIFO, 2*DATA_W bits deep, MSB-first
// Ports: clk_i, cke_i, arst_i, rst_i; write_i/wwidth_i/wdata_i push the top wwidth_i
//        bits of wdata_i; wlevel_o free bits; read_i/rwidth_i pop rwidth_i bits;
//        rdata_o head bits right-aligned (upper bits 0); rlevel_o stored bits.
module iob_bfifo #(
    parameter int DATA_W = 21
) (
    input  logic                        clk_i,
    input  logic                        cke_i,
    input  logic                        arst_i,
    input  logic                        rst_i,
    input  logic                        write_i,
    input  logic [$clog2(DATA_W):0]     wwidth_i,
    input  logic [DATA_W-1:0]           wdata_i,
    output logic [$clog2(2*DATA_W):0]   wlevel_o,
    input  logic                        read_i,
    input  logic [$clog2(DATA_W):0]     rwidth_i,
    output logic [DATA_W-1:0]           rdata_o,
    output logic [$clog2(2*DATA_W):0]   rlevel_o
);

    localparam int BUF_W   = 2 * DATA_W;
    localparam int LEVEL_W = $clog2(BUF_W) + 1;

    // Stored bits are left-aligned: oldest bit at data_q[BUF_W-1], and every
    // bit below the fill level is kept zero so pushes can simply OR in.
    logic [BUF_W-1:0]   data_q;
    logic [BUF_W-1:0]   data_nxt;
    logic [LEVEL_W-1:0] level_q;
    logic [LEVEL_W-1:0] level_nxt;
    logic [DATA_W-1:0]  wmask;
    logic [BUF_W-1:0]   wfield;

    assign wmask  = ~({DATA_W{1'b1}} >> wwidth_i);
    assign wfield = {wdata_i & wmask, {DATA_W{1'b0}}};

    always_comb begin
        data_nxt  = data_q;
        level_nxt = level_q;
        if (write_i) begin
            data_nxt  = data_q | (wfield >> level_q);
            level_nxt = level_q + LEVEL_W'(wwidth_i);
        end else if (read_i) begin
            data_nxt  = data_q << rwidth_i;
            level_nxt = level_q - LEVEL_W'(rwidth_i);
        end
    end

    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            data_q  <= '0;
            level_q <= '0;
        end else if (cke_i) begin
            if (rst_i) begin
                data_q  <= '0;
                level_q <= '0;
            end else begin
                data_q  <= data_nxt;
                level_q <= level_nxt;
            end
        end
    end

    assign rdata_o  = DATA_W'(data_q >> (LEVEL_W'(BUF_W) - LEVEL_W'(rwidth_i)));
    assign rlevel_o = level_q;
    assign wlevel_o = LEVEL_W'(BUF_W) - level_q;

endmodule

// File: rtl/iob_reg_r.sv
// rtl/iob_reg_r.sv - register with clock enable, async and sync reset to RST_VAL
// Ports: clk_i, cke_i (hold when low), arst_i (async, high), rst_i (sync, high),
//        data_i (next value), data_o (registered value).
module iob_reg_r #(
    parameter int                 DATA_W  = 1,
    parameter logic [DATA_W-1:0]  RST_VAL = '0
) (
    input  logic              clk_i,
    input  logic              cke_i,
    input  logic              arst_i,
    input  logic              rst_i,
    input  logic [DATA_W-1:0] data_i,
    output logic [DATA_W-1:0] data_o
);

    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            data_o <= RST_VAL;
        end else if (cke_i) begin
            if (rst_i) begin
                data_o <= RST_VAL;
            end else begin
                data_o <= data_i;
            end
        end
    end

endmodule

// File: rtl/iob_unpack.sv
// rtl/iob_unpack.sv - unpacks DATA_W-bit packed words into width_i-bit fields
// Ports: clk_i, cke_i, arst_i (async), rst_i (sync), wrap_i, width_i;
//        read_o/rready_i/rdata_i upstream packed-word FIFO (data the cycle after read_o);
//        write_o/wready_i/wdata_o downstream field FIFO (field in wdata_o[width_i-1:0]).
module iob_unpack
    import iob_unpack_pkg::*;
#(
    parameter int DATA_W = 21
) (
    input  logic                    clk_i,
    input  logic                    cke_i,
    input  logic                    arst_i,
    input  logic                    rst_i,
    input  logic                    wrap_i,
    input  logic [$clog2(DATA_W):0] width_i,
    output logic                    read_o,
    input  logic                    rready_i,
    input  logic [DATA_W-1:0]       rdata_i,
    output logic                    write_o,
    input  logic                    wready_i,
    output logic [DATA_W-1:0]       wdata_o
);

    localparam int WIDTH_W = $clog2(DATA_W) + 1;
    localparam int SUM_W   = $clog2(DATA_W) + 2;
    localparam int LEVEL_W = $clog2(2 * DATA_W) + 1;

    unpack_state_t        state;
    logic [1:0]           pcnt_q;
    logic [1:0]           pcnt_nxt;
    logic [WIDTH_W-1:0]   wrap_acc_q;
    logic [WIDTH_W-1:0]   wrap_acc_nxt;
    logic [SUM_W-1:0]     acc_sum;
    logic [WIDTH_W-1:0]   push_width;
    logic [LEVEL_W-1:0]   fifo_free;
    logic [LEVEL_W-1:0]   fifo_level;
    logic                 fifo_push;
    logic                 fifo_pop;
    logic                 width_ok;

    assign state      = unpack_state_t'(pcnt_q);
    assign acc_sum    = SUM_W'(wrap_acc_q) + SUM_W'(width_i);
    assign push_width = wrap_i ? wrap_acc_q : WIDTH_W'(DATA_W);
    assign width_ok   = (width_i != '0);

    always_comb begin
        pcnt_nxt     = pcnt_q + 2'd1;
        wrap_acc_nxt = wrap_acc_q;
        read_o       = 1'b0;
        write_o      = 1'b0;
        fifo_push    = 1'b0;
        fifo_pop     = 1'b0;
        case (state)
            CALC_PUSH_WIDTH: begin
                // Grows wrap_acc one field at a time until another field would not fit.
                if (wrap_i && (acc_sum <= SUM_W'(DATA_W))) begin
                    wrap_acc_nxt = WIDTH_W'(acc_sum);
                    pcnt_nxt     = pcnt_q;
                end
            end
            WAIT_DATA: begin
                // Strobes are gated so the upstream FIFO never pops while we hold or clear.
                if (width_ok && rready_i && (fifo_free >= LEVEL_W'(push_width))) begin
                    read_o = cke_i & ~rst_i;
                end else begin
                    pcnt_nxt = WAIT_POP;
                end
            end
            PUSH_DATA: begin
                fifo_push = 1'b1;
            end
            WAIT_POP: begin
                if (width_ok && wready_i && (fifo_level >= LEVEL_W'(width_i))) begin
                    write_o  = cke_i & ~rst_i;
                    fifo_pop = 1'b1;
                end
                pcnt_nxt = WAIT_DATA;
            end
        endcase
    end

    iob_reg_r #(
        .DATA_W (2),
        .RST_VAL(2'd0)
    ) u_pcnt_reg (
        .clk_i (clk_i),
        .cke_i (cke_i),
        .arst_i(arst_i),
        .rst_i (rst_i),
        .data_i(pcnt_nxt),
        .data_o(pcnt_q)
    );

    iob_reg_r #(
        .DATA_W (WIDTH_W),
        .RST_VAL('0)
    ) u_wrap_acc_reg (
        .clk_i (clk_i),
        .cke_i (cke_i),
        .arst_i(arst_i),
        .rst_i (rst_i),
        .data_i(wrap_acc_nxt),
        .data_o(wrap_acc_q)
    );

    iob_bfifo #(
        .DATA_W(DATA_W)
    ) u_bfifo (
        .clk_i   (clk_i),
        .cke_i   (cke_i),
        .arst_i  (arst_i),
        .rst_i   (rst_i),
        .write_i (fifo_push),
        .wwidth_i(push_width),
        .wdata_i (rdata_i),
        .wlevel_o(fifo_free),
        .read_i  (fifo_pop),
        .rwidth_i(width_i),
        .rdata_o (wdata_o),
        .rlevel_o(fifo_level)
    );

endmodule

// File: tb/tb_iob_unpack.sv
// tb/tb_iob_unpack.sv - self-checking bench for iob_unpack
module tb_iob_unpack;

    localparam int DATA_W = 21;

    logic              clk;
    logic              cke_i;
    logic              arst_i;
    logic              rst_i;
    logic              wrap_i;
    logic [5:0]        width_i;
    logic              read_o;
    logic              rready_i;
    logic [DATA_W-1:0] rdata_i;
    logic              write_o;
    logic              wready_i;
    logic [DATA_W-1:0] wdata_o;

    int tests_run;
    int tests_failed;
    int last_reads;
    int last_writes;

    logic [DATA_W-1:0] up_q[$];
    int                exp_q[$];

    iob_unpack #(.DATA_W(DATA_W)) dut (
        .clk_i   (clk),
        .cke_i   (cke_i),
        .arst_i  (arst_i),
        .rst_i   (rst_i),
        .wrap_i  (wrap_i),
        .width_i (width_i),
        .read_o  (read_o),
        .rready_i(rready_i),
        .rdata_i (rdata_i),
        .write_o (write_o),
        .wready_i(wready_i),
        .wdata_o (wdata_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: concatenate the kept MSBs of every word, then cut width-bit fields.
    task automatic build_expect(input int width, input bit wrap);
        bit bits[$];
        int pw;
        int f;
        exp_q.delete();
        pw = wrap ? (DATA_W / width) * width : DATA_W;
        foreach (up_q[i])
            for (int b = DATA_W - 1; b >= DATA_W - pw; b--)
                bits.push_back(up_q[i][b]);
        while (bits.size() >= width) begin
            f = 0;
            for (int k = 0; k < width; k++) f = (f << 1) | int'(bits.pop_front());
            exp_q.push_back(f);
        end
    endtask

    task automatic setup(input int width, input bit wrap);
        @(negedge clk);
        width_i  = 6'(width);
        wrap_i   = wrap;
        rst_i    = 1'b1;
        cke_i    = 1'b1;
        rready_i = 1'b1;
        wready_i = 1'b1;
        #1;
        check("rst_read", 64'(read_o), 64'd0);
        check("rst_write", 64'(write_o), 64'd0);
        @(negedge clk);
        rst_i = 1'b0;
        #1;
        check("rst_wdata", 64'(wdata_o), 64'd0);
    endtask

    task automatic run_stream(input string tag, input int width, input bit wrap,
                              input int rstall, input int wstall, input int ckestall,
                              input int whold, input int hold_reads);
        int reads;
        int writes;
        int cyc;
        int nwords;
        nwords = up_q.size();
        build_expect(width, wrap);
        reads  = 0;
        writes = 0;
        cyc    = 0;
        while (exp_q.size() > 0 && cyc < 4000) begin
            if (whold > 0 && cyc == whold) check({tag, "_hold_reads"}, 64'(reads), 64'(hold_reads));
            @(negedge clk);
            cke_i    = ($urandom_range(0, 99) >= ckestall);
            rready_i = (up_q.size() > 0) && ($urandom_range(0, 99) >= rstall);
            wready_i = (cyc >= whold) && ($urandom_range(0, 99) >= wstall);
            #1;
            if (read_o) begin
                if (up_q.size() == 0) check({tag, "_read_empty"}, 64'd1, 64'd0);
                else rdata_i = up_q.pop_front();
                reads++;
            end
            if (write_o) begin
                check({tag, "_field"}, 64'(wdata_o), 64'(exp_q.pop_front()));
                writes++;
            end
            cyc++;
        end
        check({tag, "_left"}, 64'(exp_q.size()), 64'd0);
        repeat (8) begin
            @(negedge clk);
            cke_i    = 1'b1;
            rready_i = 1'b0;
            wready_i = 1'b1;
            #1;
            check({tag, "_idle"}, 64'({read_o, write_o}), 64'd0);
        end
        check({tag, "_reads"}, 64'(reads), 64'(nwords));
        last_reads  = reads;
        last_writes = writes;
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        arst_i   = 1'b1;
        rst_i    = 1'b0;
        cke_i    = 1'b1;
        wrap_i   = 1'b0;
        width_i  = 6'd7;
        rready_i = 1'b1;
        wready_i = 1'b1;
        rdata_i  = '0;
        #1;
        check("arst_read", 64'(read_o), 64'd0);
        check("arst_write", 64'(write_o), 64'd0);
        check("arst_wdata", 64'(wdata_o), 64'd0);
        repeat (2) @(negedge clk);
        arst_i = 1'b0;

        // 1: all-ones then all-zeros word, width 7
        setup(7, 1'b0);
        up_q = {21'h1FFFFF, 21'h0};
        run_stream("t1", 7, 1'b0, 0, 0, 0, 0, 0);
        check("t1_read_count", 64'(last_reads), 64'd2);
        check("t1_write_count", 64'(last_writes), 64'd6);

        // 2: five random words, width 5, no wrap -> 21 fields, nothing left over
        setup(5, 1'b0);
        up_q.delete();
        repeat (5) up_q.push_back(21'($urandom()));
        run_stream("t2", 5, 1'b0, 0, 0, 0, 0, 0);
        check("t2_write_count", 64'(last_writes), 64'd21);

        // 3: wrap mode, width 5 -> 20 bits kept, LSB dropped
        setup(5, 1'b1);
        up_q = {21'h1ABCDE};
        run_stream("t3", 5, 1'b1, 0, 0, 0, 0, 0);
        check("t3_write_count", 64'(last_writes), 64'd4);

        // 4: full-width fields with the output blocked for 10 cycles
        setup(21, 1'b0);
        up_q.delete();
        repeat (4) up_q.push_back(21'($urandom()));
        run_stream("t4", 21, 1'b0, 0, 0, 0, 10, 2);

        // 5: async reset mid-stream, then sync reset mid-stream, then a clean stream
        setup(7, 1'b0);
        up_q.delete();
        repeat (3) up_q.push_back(21'h155555 | 21'($urandom()));
        repeat (12) begin
            @(negedge clk);
            rready_i = (up_q.size() > 0);
            wready_i = 1'b1;
            cke_i    = 1'b1;
            #1;
            if (read_o && up_q.size() > 0) rdata_i = up_q.pop_front();
        end
        @(negedge clk);
        arst_i = 1'b1;
        #1;
        check("t5_arst_read", 64'(read_o), 64'd0);
        check("t5_arst_write", 64'(write_o), 64'd0);
        check("t5_arst_wdata", 64'(wdata_o), 64'd0);
        @(negedge clk);
        arst_i = 1'b0;
        up_q.delete();
        repeat (2) up_q.push_back(21'h1FFFFF);
        repeat (9) begin
            @(negedge clk);
            rready_i = (up_q.size() > 0);
            wready_i = 1'b0;
            #1;
            if (read_o && up_q.size() > 0) rdata_i = up_q.pop_front();
        end
        setup(7, 1'b0);
        up_q.delete();
        repeat (2) up_q.push_back(21'($urandom()));
        run_stream("t5", 7, 1'b0, 0, 0, 0, 0, 0);
        check("t5_write_count", 64'(last_writes), 64'd6);

        // 6: every width, both wrap modes, random stalls and clock-enable gaps
        for (int w = 1; w <= DATA_W; w++) begin
            for (int m = 0; m < 2; m++) begin
                setup(w, m[0]);
                up_q.delete();
                repeat (3) up_q.push_back(21'($urandom()));
                run_stream($sformatf("t6_w%0d_m%0d", w, m), w, m[0], 30, 30, 10, 0, 0);
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
